// File: rtl/debug_uart_mc.sv
// Full-duplex debug UART: shared baud prescaler, TX engine and
// oversampled RX engine with false-start rejection and sticky errors.
module debug_uart_mc #(
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1,
  parameter int OVERSAMPLE     = 16,
  parameter int BAUD_DIV_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sync_reset,
  input  logic                      UART_enable,
  input  logic [BAUD_DIV_WIDTH-1:0] baud_div,
  input  logic                      tx_valid,
  input  logic [DATA_WIDTH-1:0]     tx_data,
  output logic                      tx_ready,
  output logic                      TX_done_pulse,
  output logic                      TXD,
  input  logic                      RXD,
  input  logic                      REN,
  output logic [DATA_WIDTH-1:0]     rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ack,
  input  logic                      err_clear,
  output logic                      parity_err,
  output logic                      frame_err,
  output logic                      overrun_err
);

  localparam int CW = $clog2(STOP_BITS * OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] BIT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] HALF_END = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam bit   HAS_PAR = (PARITY_MODE != 0);
  localparam logic ODD     = (PARITY_MODE == 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  logic [BAUD_DIV_WIDTH-1:0] pre_cnt;
  logic [BAUD_DIV_WIDTH-1:0] pre_top;
  logic                      tick;
  logic                      live;

  // Compare with >= so a shrunk divisor wraps on the next cycle.
  assign pre_top = (baud_div == '0) ? '0
                 : baud_div - BAUD_DIV_WIDTH'(1);
  assign tick = UART_enable && (pre_cnt >= pre_top);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
      live    <= 1'b0;
    end else begin
      live <= !sync_reset;
      if (sync_reset || !UART_enable || tick)
        pre_cnt <= '0;
      else
        pre_cnt <= pre_cnt + BAUD_DIV_WIDTH'(1);
    end
  end

  tx_state_t             tx_state, tx_state_n;
  logic [CW-1:0]         tx_cnt, tx_cnt_n;
  logic [BW-1:0]         tx_bit, tx_bit_n;
  logic [DATA_WIDTH-1:0] tx_buf, tx_buf_n;
  logic                  done_n;
  logic                  tx_end;
  logic                  tx_par;

  assign tx_ready = live && UART_enable && (tx_state == TX_IDLE);
  assign tx_par   = (^tx_buf) ^ ODD;
  assign tx_end   = tick && (tx_cnt ==
                    ((tx_state == TX_STOP) ? STOP_END : BIT_END));

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_buf_n   = tx_buf;
    done_n     = 1'b0;
    if (!UART_enable) begin
      tx_state_n = TX_IDLE;
      tx_cnt_n   = '0;
      tx_bit_n   = '0;
    end else begin
      if (tx_state != TX_IDLE && tick)
        tx_cnt_n = tx_end ? '0 : tx_cnt + CW'(1);
      case (tx_state)
        TX_IDLE:
          if (tx_valid && tx_ready) begin
            tx_state_n = TX_START;
            tx_cnt_n   = '0;
            tx_bit_n   = '0;
            tx_buf_n   = tx_data;
          end
        TX_START:
          if (tx_end) tx_state_n = TX_DATA;
        TX_DATA:
          if (tx_end) begin
            if (tx_bit == LAST_BIT) begin
              tx_bit_n   = '0;
              tx_state_n = HAS_PAR ? TX_PARITY : TX_STOP;
            end else begin
              tx_bit_n = tx_bit + BW'(1);
            end
          end
        TX_PARITY:
          if (tx_end) tx_state_n = TX_STOP;
        TX_STOP:
          if (tx_end) begin
            tx_state_n = TX_IDLE;
            done_n     = 1'b1;
          end
        default: tx_state_n = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    case (tx_state)
      TX_START:  TXD = 1'b0;
      TX_DATA:   TXD = tx_buf[tx_bit];
      TX_PARITY: TXD = tx_par;
      default:   TXD = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_buf        <= '0;
      TX_done_pulse <= 1'b0;
    end else if (sync_reset) begin
      tx_state      <= TX_IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_buf        <= '0;
      TX_done_pulse <= 1'b0;
    end else begin
      tx_state      <= tx_state_n;
      tx_cnt        <= tx_cnt_n;
      tx_bit        <= tx_bit_n;
      tx_buf        <= tx_buf_n;
      TX_done_pulse <= done_n;
    end
  end

  logic                  rx_s1, rx_s2, rx_prev;
  rx_state_t             rx_state, rx_state_n;
  logic [CW-1:0]         rx_cnt, rx_cnt_n;
  logic [BW-1:0]         rx_bit, rx_bit_n;
  logic [DATA_WIDTH-1:0] rx_sh, rx_sh_n;
  logic                  rx_par, rx_par_n;
  logic                  rx_end;
  logic                  stop_evt;
  logic                  par_bad;

  assign rx_end  = tick && (rx_cnt ==
                   ((rx_state == RX_START) ? HALF_END : BIT_END));
  assign par_bad = HAS_PAR && (rx_par != ((^rx_sh) ^ ODD));

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_sh_n    = rx_sh;
    rx_par_n   = rx_par;
    stop_evt   = 1'b0;
    if (!UART_enable) begin
      rx_state_n = RX_IDLE;
      rx_cnt_n   = '0;
      rx_bit_n   = '0;
    end else begin
      if (rx_state != RX_IDLE && tick)
        rx_cnt_n = rx_end ? '0 : rx_cnt + CW'(1);
      case (rx_state)
        RX_IDLE:
          if (REN && rx_prev && !rx_s2) begin
            rx_state_n = RX_START;
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
          end
        RX_START:
          if (rx_end) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA:
          if (rx_end) begin
            rx_sh_n[rx_bit] = rx_s2;
            if (rx_bit == LAST_BIT) begin
              rx_bit_n   = '0;
              rx_state_n = HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_n = rx_bit + BW'(1);
            end
          end
        RX_PARITY:
          if (rx_end) begin
            rx_par_n   = rx_s2;
            rx_state_n = RX_STOP;
          end
        RX_STOP:
          if (rx_end) begin
            stop_evt   = 1'b1;
            rx_state_n = RX_IDLE;
          end
        default: rx_state_n = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_sh       <= '0;
      rx_par      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (sync_reset) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_sh       <= '0;
      rx_par      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_s1    <= RXD;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_sh    <= rx_sh_n;
      rx_par   <= rx_par_n;
      if (stop_evt) rx_data <= rx_sh;
      rx_valid <= stop_evt || (rx_valid && !rx_ack);
      // Setting events take priority over err_clear.
      frame_err <= (stop_evt && !rx_s2)
                || (frame_err && !err_clear);
      parity_err <= (stop_evt && par_bad)
                 || (parity_err && !err_clear);
      overrun_err <= (stop_evt && rx_valid && !rx_ack)
                  || (overrun_err && !err_clear);
    end
  end

endmodule

// File: doc/debug_uart_mc.md
Name: debug_uart_mc

Overview:
- Full-duplex, parametrised UART for the on-chip debugger link; successor to the half-duplex 8051-serial-based debug UART.
- Self-contained TX and RX engines; no dependency on the 8051 serial core.
- Runtime baud divisor, configurable data width, parity and stop bits, 16x-style oversampled RX with false-start rejection, and sticky error reporting.
- Sits between the debug coprocessor command FSM and the board RXD/TXD pins.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 0, parity: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted; legal values 1 or 2.
- OVERSAMPLE, 16, baud ticks per bit; must be even and at least 4.
- BAUD_DIV_WIDTH, 16, width of the runtime divisor.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- sync_reset  input  1  synchronous reset; same effect as reset_n, including the sticky error flags.
- UART_enable  input  1  0 freezes the prescaler and holds both FSMs in idle.
- baud_div  input  BAUD_DIV_WIDTH  clock cycles per baud tick; 0 is treated as 1.
- tx_valid  input  1  TX request.
- tx_data  input  DATA_WIDTH  TX payload.
- tx_ready  output  1  TX can accept a word.
- TX_done_pulse  output  1  one-cycle pulse at the end of a frame.
- TXD  output  1  serial out; idles high.
- RXD  input  1  serial in; asynchronous.
- REN  input  1  receive enable.
- rx_data  output  DATA_WIDTH  last received word.
- rx_valid  output  1  level; an unread word is held.
- rx_ack  input  1  consumes the held word.
- err_clear  input  1  clears the sticky error flags.
- parity_err  output  1  sticky.
- frame_err  output  1  sticky.
- overrun_err  output  1  sticky.

Behaviour:
- Reset values: TXD = 1, tx_ready = 0 (it rises on the first enabled cycle), TX_done_pulse = 0, rx_data = 0, rx_valid = 0, all error flags 0, both FSMs idle, prescaler = 0, RXD synchroniser = 1.
- Prescaler:
  - Counts 0..max(baud_div,1)-1 while UART_enable = 1; tick asserts when count = max-1, then the counter wraps.
  - Cleared when UART_enable = 0 or sync_reset = 1.
  - A new baud_div value takes effect at the next wrap; if count is already at or above the new maximum, the counter wraps on the next cycle.
- Bit time is OVERSAMPLE ticks.
- TX FSM: TX_IDLE -> TX_START -> TX_DATA -> [TX_PARITY] -> TX_STOP -> TX_IDLE.
  - tx_ready = 1 only in TX_IDLE with UART_enable = 1.
  - tx_valid & tx_ready: latch tx_data; next cycle enter TX_START with TXD = 0 and the bit-tick counter cleared.
  - Each state lasts OVERSAMPLE ticks. Data goes out LSB first, DATA_WIDTH bits.
  - TX_PARITY exists only when PARITY_MODE != 0. Even mode: XOR of the data bits. Odd mode: its inverse.
  - TX_STOP drives 1 for STOP_BITS × OVERSAMPLE ticks.
  - On leaving TX_STOP: TX_done_pulse = 1 for exactly one cycle and tx_ready = 1 in the same cycle.
  - A back-to-back tx_valid is accepted in that cycle.
- RX FSM: RX_IDLE -> RX_START -> RX_DATA -> [RX_PARITY] -> RX_STOP -> RX_IDLE.
  - RXD passes through a 2-FF synchroniser.
  - In RX_IDLE with REN = 1, a synchronised 1->0 transition enters RX_START and clears the tick counter.
  - At OVERSAMPLE/2 ticks, sample the line: 1 = false start, return to RX_IDLE with no flags; 0 = continue.
  - Subsequent samples are taken every OVERSAMPLE ticks (mid-bit), LSB first.
  - Only the first stop bit is checked; RX returns to RX_IDLE immediately after the stop sample.
  - Stop-sample cycle, all registered and visible the next cycle:
    - rx_data is updated and rx_valid is set;
    - frame_err is set if stop = 0;
    - parity_err is set on mismatch;
    - overrun_err is set if rx_valid was already 1 and rx_ack was not asserted in the same cycle. The new word overwrites the old one.
  - The word is delivered even when it has errors.
- REN deasserted mid-frame: the current frame completes; no new frame starts.
- rx_ack clears rx_valid the next cycle. If rx_ack coincides with a new word, rx_valid stays 1 and there is no overrun.
- err_clear clears all three flags. If a set event coincides with err_clear, the set wins.
- UART_enable = 0 mid-frame: both FSMs return to idle next cycle, TXD = 1, no done pulse, rx_valid and error flags are kept.
- Asynchronous reset mid-frame: every output returns to its reset value immediately.
- Frame length in cycles = (1 + DATA_WIDTH + (PARITY_MODE != 0) + STOP_BITS) × OVERSAMPLE × max(baud_div,1).

Test Plan:
- Defaults with PARITY_MODE = 2 and baud_div = 4: send 0xA5. TXD is low for 64 cycles, then the bits 1,0,1,0,0,1,0,1, then parity 0, then stop. TX_done_pulse fires 704 cycles after TX_START; tx_ready is high in the same cycle.
- Loop TXD to RXD and send 0x3C, then 0xC3 back-to-back. rx_data = 0x3C then 0xC3, each after rx_ack. No error flags; the second frame's start bit begins on the cycle after TX_done_pulse.
- Inject a 20-cycle low glitch on RXD with baud_div = 4 (mid-bit sample falls at 32 cycles). Response: false start, rx_valid stays 0, no flags.
- Drive a frame with stop = 0 and wrong parity. frame_err = 1, parity_err = 1, rx_valid = 1. Assert err_clear: both flags clear, rx_data is retained.
- Receive two words without rx_ack. overrun_err = 1 and rx_data = second word. Repeat with rx_ack asserted on the second stop-sample cycle: overrun_err stays 0.
- Drop UART_enable at data bit 3 of TX. TXD = 1 next cycle, no TX_done_pulse, tx_ready = 0 while UART_enable = 0. Re-enable and send 0x55: frame is correct.
